l2_mem_burst_ctrl: RTL
======================

// Module: l2_mem_burst_ctrl
// PURPOSE
//  Clocked sequencer for the L2 <-> main-memory 64-bit bus. Arbitrates line refills (L2 miss) against
//  dirty-victim writebacks, drives addr/we/addrstb_MEM, counts BURST_LENGTH stb-toggle beats, and hands
//  each refill beat to the L2 array, or fetches each writeback beat from it. Sits between L2 tag/data logic and MainMemory.
// PARAMETERS
//  ADDR_WIDTH    32   byte address width
//  DATA_WIDTH    64   memory bus width (one beat)
//  BURST_LENGTH  8    beats per line (line = 64 B, addr[5:0] forced 0)
//  TIMEOUT       255  max clk cycles between stb edges before ERR
// PORTS
//  clk          in   1   rising-edge clock
//  addrstb_L1   in   1   reset, asynchronous, active-low
//  fill_req     in   1   refill request; level, held until fill_done
//  fill_addr    in   32  refill address (any byte in line)
//  wb_req       in   1   writeback request; level, held until wb_done
//  wb_addr      in   32  victim line address
//  wb_data      in   64  victim beat selected by wb_beat (valid same cycle)
//  wb_beat      out  3   index of writeback beat to present on wb_data
//  fill_gnt     out  1   1-cycle pulse: fill accepted
//  wb_gnt       out  1   1-cycle pulse: writeback accepted
//  fill_data    out  64  registered refill beat
//  fill_beat    out  3   index of fill_data beat
//  fill_vld     out  1   1-cycle pulse: fill_data/fill_beat valid
//  fill_done    out  1   1-cycle pulse: refill complete
//  wb_done      out  1   1-cycle pulse: writeback complete
//  err          out  1   1-cycle pulse: beat timeout, transfer aborted
//  busy         out  1   high in any state except IDLE
//  stb          in   1   memory beat strobe; each toggle = one beat (async to clk)
//  we_MEM       out  1   1 = memory read (refill), 0 = memory write (writeback)
//  addrstb_MEM  out  1   toggled once per transfer to launch it
//  addr_MEM     out  32  line-aligned address
//  mem_rdata    in   64  memory read data (stable between stb edges)
//  mem_wdata    out  64  write data (= wb_data when mem_oe)
//  mem_oe       out  1   1 = drive data_MEM bus with mem_wdata
// BEHAVIOUR
//  Reset (addrstb_L1=0): state IDLE; all pulses, busy, mem_oe, addrstb_MEM = 0; we_MEM = 1; addr_MEM,
//   fill_data, mem_wdata = 0; counters/sync flops = 0. Mid-burst reset aborts silently (memory reset jointly).
//  stb sync: 3 flops s1,s2,s3; beat_edge = s2^s3. mem_rdata sampled in the beat_edge cycle.
//  FSM IDLE -> SETUP -> LAUNCH -> BURST -> DONE -> IDLE; BURST -> ERR -> IDLE.
//  IDLE: wb_req wins over fill_req (victim leaves before refill of same index). On grant: latch
//   addr_MEM = {addr[31:6],6'b0}; we_MEM = 0/1 for wb/fill; mem_oe = 1 for wb; wb_beat = 0; pulse *_gnt.
//  SETUP: 1 cycle, addr/we stable. LAUNCH: addrstb_MEM <= ~addrstb_MEM; beat count = 0, watchdog = 0.
//  BURST per beat_edge: fill -> fill_data <= mem_rdata, fill_beat <= count, fill_vld pulses next cycle;
//   wb -> wb_beat <= count+1 (mem_wdata follows wb_data combinationally). count++.
//   Edge on beat BURST_LENGTH-1 -> DONE. Edge-to-vld latency: stb toggle -> fill_vld in 3..4 clk.
//  Watchdog: cleared on each beat_edge, +1 otherwise; reaching TIMEOUT -> ERR (count ignored).
//  DONE: pulse fill_done or wb_done; mem_oe = 0; we_MEM = 1. ERR: pulse err; mem_oe = 0; no *_done.
//  Requests arriving during busy wait in IDLE; both pending at DONE -> next grant is still wb-first.
//  stb edges in IDLE/SETUP/DONE are ignored (no count change). wb_beat saturates at BURST_LENGTH-1.
// TESTING
//  fill_req, fill_addr=0x0000_1234, mem returns beats 0x..00..0x..07 -> addr_MEM=0x0000_1200, we_MEM=1,
//   one addrstb_MEM toggle, 8 fill_vld with fill_beat 0..7 matching data, one fill_done.
//  wb_req, wb_addr=0x00AB_CDC0, wb_data=beat*0x1111 -> we_MEM=0, mem_oe=1, memory captures 8 beats
//   0x0000..0x7777 in order, wb_done, mem_oe=0.
//  fill_req and wb_req same cycle -> wb_gnt first, wb_done, then fill_gnt; exactly 2 addrstb_MEM toggles.
//  Burst with memory stalling after beat 3 -> err pulse TIMEOUT cycles after last edge, busy=0, no fill_done.
//  addrstb_L1 low during beat 5 -> all outputs reset values next cycle; new fill after release completes.
//  Spurious stb toggle while IDLE, then fill -> still exactly 8 fill_vld, beats 0..7.

Source files
------------

// File: rtl/l2_mem_burst_ctrl_if.sv
// Bus bundle between the L2 burst controller (slave) and the L2 tag/data logic
// plus MainMemory (master).
interface l2_mem_burst_ctrl_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LENGTH = 8
);
    localparam int BW = $clog2(BURST_LENGTH);

    logic                  fill_req;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  wb_req;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [BW-1:0]         wb_beat;
    logic                  fill_gnt;
    logic                  wb_gnt;
    logic [DATA_WIDTH-1:0] fill_data;
    logic [BW-1:0]         fill_beat;
    logic                  fill_vld;
    logic                  fill_done;
    logic                  wb_done;
    logic                  err;
    logic                  busy;
    logic                  stb;
    logic                  we_MEM;
    logic                  addrstb_MEM;
    logic [ADDR_WIDTH-1:0] addr_MEM;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_oe;

    modport slave (
        input  fill_req, fill_addr, wb_req, wb_addr, wb_data, stb, mem_rdata,
        output wb_beat, fill_gnt, wb_gnt, fill_data, fill_beat, fill_vld, fill_done,
               wb_done, err, busy, we_MEM, addrstb_MEM, addr_MEM, mem_wdata, mem_oe
    );

    modport master (
        output fill_req, fill_addr, wb_req, wb_addr, wb_data, stb, mem_rdata,
        input  wb_beat, fill_gnt, wb_gnt, fill_data, fill_beat, fill_vld, fill_done,
               wb_done, err, busy, we_MEM, addrstb_MEM, addr_MEM, mem_wdata, mem_oe
    );
endinterface

// File: rtl/l2_mem_burst_ctrl.sv
// L2 <-> main-memory burst sequencer: writeback-first arbitration, stb-toggle beat
// counting through a 3-flop synchronizer, and a per-beat watchdog.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for wb_req / fill_req (wb wins)
// S_SETUP  | address and direction stable for one cycle
// S_LAUNCH | toggle addrstb_MEM, clear beat count, arm watchdog
// S_BURST  | count stb beats, move data, watch for stalls
// S_DONE   | pulse fill_done / wb_done
// S_ERR    | pulse err after a beat timeout
module l2_mem_burst_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LENGTH = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                  i_clk,
    input  logic                  i_addrstb_L1,
    l2_mem_burst_ctrl_if.slave    io_bus
);
    localparam int BW  = $clog2(BURST_LENGTH);
    localparam int OFF = $clog2(BURST_LENGTH * DATA_WIDTH / 8);
    localparam int WW  = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST    = BW'(BURST_LENGTH - 1);
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LAUNCH, S_BURST, S_DONE, S_ERR} state_t;

    state_t                r_state;
    logic                  r_s1, r_s2, r_s3;
    logic [BW-1:0]         r_cnt;
    logic [WW-1:0]         r_wdog;
    logic                  r_is_wb;
    logic                  r_vld_pend;
    logic                  r_fill_gnt, r_wb_gnt, r_fill_vld, r_fill_done, r_wb_done, r_err;
    logic                  r_busy, r_we, r_astb, r_oe;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic [BW-1:0]         r_fill_beat;
    logic [BW-1:0]         r_wb_beat;

    logic w_beat_edge;
    logic w_unused_lsbs;

    assign w_beat_edge   = r_s2 ^ r_s3;
    assign w_unused_lsbs = ^{io_bus.fill_addr[OFF-1:0], io_bus.wb_addr[OFF-1:0]};

    always_ff @(posedge i_clk or negedge i_addrstb_L1) begin
        if (!i_addrstb_L1) begin
            r_state     <= S_IDLE;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_cnt       <= '0;
            r_wdog      <= '0;
            r_is_wb     <= 1'b0;
            r_vld_pend  <= 1'b0;
            r_fill_gnt  <= 1'b0;
            r_wb_gnt    <= 1'b0;
            r_fill_vld  <= 1'b0;
            r_fill_done <= 1'b0;
            r_wb_done   <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_we        <= 1'b1;
            r_astb      <= 1'b0;
            r_oe        <= 1'b0;
            r_addr      <= '0;
            r_fill_data <= '0;
            r_fill_beat <= '0;
            r_wb_beat   <= '0;
        end else begin
            r_s1        <= io_bus.stb;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_fill_gnt  <= 1'b0;
            r_wb_gnt    <= 1'b0;
            r_fill_done <= 1'b0;
            r_wb_done   <= 1'b0;
            r_err       <= 1'b0;
            // fill_vld trails the data capture by one cycle so data is already settled
            r_fill_vld  <= r_vld_pend;
            r_vld_pend  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.wb_req) begin
                        r_wb_gnt  <= 1'b1;
                        r_is_wb   <= 1'b1;
                        r_addr    <= {io_bus.wb_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        r_we      <= 1'b0;
                        r_oe      <= 1'b1;
                        r_wb_beat <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SETUP;
                    end else if (io_bus.fill_req) begin
                        r_fill_gnt <= 1'b1;
                        r_is_wb    <= 1'b0;
                        r_addr     <= {io_bus.fill_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        r_we       <= 1'b1;
                        r_oe       <= 1'b0;
                        r_wb_beat  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: r_state <= S_LAUNCH;
                S_LAUNCH: begin
                    r_astb  <= ~r_astb;
                    r_cnt   <= '0;
                    r_wdog  <= WD_LOAD;
                    r_state <= S_BURST;
                end
                S_BURST: begin
                    if (w_beat_edge) begin
                        r_wdog <= WD_LOAD;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_is_wb) begin
                            r_wb_beat <= (r_cnt == LAST) ? LAST : r_cnt + 1'b1;
                        end else begin
                            r_fill_data <= io_bus.mem_rdata;
                            r_fill_beat <= r_cnt;
                            r_vld_pend  <= 1'b1;
                        end
                        if (r_cnt == LAST) begin
                            r_oe    <= 1'b0;
                            r_we    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else if (r_wdog == '0) begin
                        r_oe    <= 1'b0;
                        r_we    <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_wdog <= r_wdog - 1'b1;
                    end
                end
                S_DONE: begin
                    r_wb_done   <= r_is_wb;
                    r_fill_done <= ~r_is_wb;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                S_ERR: begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.wb_beat     = r_wb_beat;
    assign io_bus.fill_gnt    = r_fill_gnt;
    assign io_bus.wb_gnt      = r_wb_gnt;
    assign io_bus.fill_data   = r_fill_data;
    assign io_bus.fill_beat   = r_fill_beat;
    assign io_bus.fill_vld    = r_fill_vld;
    assign io_bus.fill_done   = r_fill_done;
    assign io_bus.wb_done     = r_wb_done;
    assign io_bus.err         = r_err;
    assign io_bus.busy        = r_busy;
    assign io_bus.we_MEM      = r_we;
    assign io_bus.addrstb_MEM = r_astb;
    assign io_bus.addr_MEM    = r_addr;
    assign io_bus.mem_oe      = r_oe;
    assign io_bus.mem_wdata   = r_oe ? io_bus.wb_data : '0;
endmodule
